// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential clear engine: walks the register index from 0 to DEPTH-1,
// requesting one zero-write per cycle while busy.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The engine leaves CLEAR straight after the last entry, so the index never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads,
// optional zero register, optional write-to-read bypass and a sequential clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int              IDX_W     = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic [DATA_W-1:0] rd_sel1, rd_sel2;
    logic              rd_valid_q, rd_valid_d;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    logic              wr_ok;
    logic              rd_ok;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // A write is only real if it lands on an implemented, writable register.
    always_comb begin
        wr_ok = wr_en && !clr_busy
                && ({1'b0, wr_addr} < DEPTH_EXT)
                && !((ZERO_REG != 0) && (wr_addr == '0));
        rd_ok = rd_en && !clr_busy;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (clr_we && (clr_idx == IDX_W'(i))) begin
                regs_d[i] = '0;
            end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_sel1 = '0;
        rd_sel2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr1 == ADDR_W'(i)) begin
                rd_sel1 = regs_q[i];
            end
            if (rd_addr2 == ADDR_W'(i)) begin
                rd_sel2 = regs_q[i];
            end
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_sel1 = '0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_sel2 = '0;
        end
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
            rd_sel1 = wr_data;
        end
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
            rd_sel2 = wr_data;
        end

        rd_valid_d = rd_ok;
        rd_data1_d = rd_ok ? rd_sel1 : rd_data1_q;
        rd_data2_d = rd_ok ? rd_sel2 : rd_data2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench driving two regfile_param configurations with shared stimulus:
// A = defaults (DEPTH 32, no zero reg, bypass), B = DEPTH 20, zero reg, no bypass.
module tb_regfile_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] rd_addr1;
    logic [4:0] rd_addr2;
    logic       clr_req;

    logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic       val_a, val_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    int         busy_cnt_a;
    int         busy_cnt_b;
    int         valid_seen;
    logic [7:0] nz_a;
    logic [7:0] nz_b;

    regfile_param #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .DEPTH    (32),
        .ZERO_REG (0),
        .BYPASS   (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd1_a),
        .rd_data2 (rd2_a),
        .rd_valid (val_a),
        .clr_req  (clr_req),
        .clr_busy (busy_a)
    );

    regfile_param #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .DEPTH    (20),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd1_b),
        .rd_data2 (rd2_b),
        .rd_valid (val_b),
        .clr_req  (clr_req),
        .clr_busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                                 input logic re, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic cr);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rd_addr1 = a1;
        rd_addr2 = a2;
        clr_req  = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        clr_req  = 1'b0;

        #12;
        checkOutput("reset_rd1_a", 32'(rd1_a), 32'h0);
        checkOutput("reset_valid_a", 32'(val_a), 32'h0);
        checkOutput("reset_busy_a", 32'(busy_a), 32'h0);
        checkOutput("reset_rd2_b", 32'(rd2_b), 32'h0);
        checkOutput("reset_busy_b", 32'(busy_b), 32'h0);
        #1 rst = 1'b0;

        // Reset mid-cycle wipes read outputs and storage.
        $display("[TB] reset behaviour");
        applyStimulus(1'b1, 5'd5, 8'hAB, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 5'd5, 1'b0);
        checkOutput("pre_reset_rd1_a", 32'(rd1_a), 32'hAB);
        checkOutput("pre_reset_rd2_b", 32'(rd2_b), 32'hAB);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_reset_rd1_a", 32'(rd1_a), 32'h0);
        checkOutput("async_reset_valid_a", 32'(val_a), 32'h0);
        checkOutput("async_reset_rd2_b", 32'(rd2_b), 32'h0);
        #2 rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 5'd5, 1'b0);
        checkOutput("post_reset_r5_a", 32'(rd1_a), 32'h0);
        checkOutput("post_reset_valid_a", 32'(val_a), 32'h1);
        checkOutput("post_reset_r5_b", 32'(rd1_b), 32'h0);

        $display("[TB] basic write/read");
        applyStimulus(1'b1, 5'd7, 8'h3C, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 5'd7, 1'b0);
        checkOutput("basic_rd1_a", 32'(rd1_a), 32'h3C);
        checkOutput("basic_rd2_a", 32'(rd2_a), 32'h3C);
        checkOutput("basic_valid_a", 32'(val_a), 32'h1);
        checkOutput("basic_rd1_b", 32'(rd1_b), 32'h3C);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd1, 5'd2, 1'b0);
        checkOutput("idle_valid_a", 32'(val_a), 32'h0);
        checkOutput("idle_hold_rd1_a", 32'(rd1_a), 32'h3C);
        checkOutput("idle_hold_rd2_b", 32'(rd2_b), 32'h3C);

        $display("[TB] bypass");
        applyStimulus(1'b1, 5'd9, 8'h11, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd9, 8'h22, 1'b1, 5'd9, 5'd7, 1'b0);
        checkOutput("bypass_on_rd1_a", 32'(rd1_a), 32'h22);
        checkOutput("bypass_off_rd1_b", 32'(rd1_b), 32'h11);
        checkOutput("bypass_other_rd2_a", 32'(rd2_a), 32'h3C);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 5'd9, 1'b0);
        checkOutput("after_bypass_rd1_b", 32'(rd1_b), 32'h22);

        $display("[TB] zero register and range");
        applyStimulus(1'b1, 5'd0, 8'hFF, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 5'd25, 1'b0);
        checkOutput("r0_written_a", 32'(rd1_a), 32'hFF);
        checkOutput("r0_zero_b", 32'(rd1_b), 32'h0);
        applyStimulus(1'b1, 5'd25, 8'h55, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd19, 8'h77, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd20, 8'h66, 1'b0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd25, 5'd19, 1'b0);
        checkOutput("r25_in_range_a", 32'(rd1_a), 32'h55);
        checkOutput("r25_dropped_b", 32'(rd1_b), 32'h0);
        checkOutput("r19_last_b", 32'(rd2_b), 32'h77);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 5'd20, 1'b0);
        checkOutput("r20_a", 32'(rd1_a), 32'h66);
        checkOutput("r20_dropped_b", 32'(rd2_b), 32'h0);

        $display("[TB] clear sequence");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 8'(i + 1), 1'b0, 5'd0, 5'd0, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd31, 5'd19, 1'b0);
        checkOutput("fill_r31_a", 32'(rd1_a), 32'h20);
        checkOutput("fill_r31_b", 32'(rd1_b), 32'h0);
        checkOutput("fill_r19_b", 32'(rd2_b), 32'h14);

        applyStimulus(1'b1, 5'd3, 8'hEE, 1'b1, 5'd3, 5'd4, 1'b1);
        checkOutput("clr_start_busy_a", 32'(busy_a), 32'h1);
        checkOutput("clr_start_busy_b", 32'(busy_b), 32'h1);
        checkOutput("clr_start_read_a", 32'(rd1_a), 32'hEE);
        checkOutput("clr_start_read_b", 32'(rd1_b), 32'h04);
        checkOutput("clr_start_rd2_a", 32'(rd2_a), 32'h05);
        checkOutput("clr_start_valid_b", 32'(val_b), 32'h1);

        busy_cnt_a = 1;
        busy_cnt_b = 1;
        valid_seen = 0;
        for (int j = 1; j <= 40; j++) begin
            if (j <= 15) begin
                applyStimulus(1'b1, 5'd2, 8'h99, 1'b1, 5'd2, 5'd3, logic'(j == 5));
                if (val_a || val_b) valid_seen++;
            end else begin
                applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0);
            end
            if (busy_a) busy_cnt_a++;
            if (busy_b) busy_cnt_b++;
        end
        checkOutput("busy_cycles_a", 32'(busy_cnt_a), 32'd32);
        checkOutput("busy_cycles_b", 32'(busy_cnt_b), 32'd20);
        checkOutput("valid_while_busy", 32'(valid_seen), 32'd0);

        nz_a = '0;
        nz_b = '0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'(i), 5'(31 - i), 1'b0);
            nz_a = nz_a | rd1_a | rd2_a;
            nz_b = nz_b | rd1_b | rd2_b;
        end
        checkOutput("cleared_all_a", 32'(nz_a), 32'h0);
        checkOutput("cleared_all_b", 32'(nz_b), 32'h0);
        checkOutput("readback_valid_a", 32'(val_a), 32'h1);

        $display("[TB] reset during clear");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 8'(i + 8'h40), 1'b0, 5'd0, 5'd0, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1);
        for (int j = 1; j <= 9; j++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0);
        end
        checkOutput("mid_clear_busy_a", 32'(busy_a), 32'h1);
        #3 rst = 1'b1;
        #1;
        checkOutput("abort_busy_a", 32'(busy_a), 32'h0);
        checkOutput("abort_busy_b", 32'(busy_b), 32'h0);
        #2 rst = 1'b0;

        nz_a = '0;
        nz_b = '0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'(i), 5'(31 - i), 1'b0);
            nz_a = nz_a | rd1_a | rd2_a;
            nz_b = nz_b | rd1_b | rd2_b;
        end
        checkOutput("abort_cleared_a", 32'(nz_a), 32'h0);
        checkOutput("abort_cleared_b", 32'(nz_b), 32'h0);

        applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1);
        checkOutput("restart_busy_a", 32'(busy_a), 32'h1);
        checkOutput("restart_busy_b", 32'(busy_b), 32'h1);
        for (int j = 1; j <= 40; j++) begin
            applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0);
        end
        checkOutput("restart_done_a", 32'(busy_a), 32'h0);
        checkOutput("restart_done_b", 32'(busy_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
